// File: rtl/pmem_loader.sv
// pmem_loader
//   Receives a framed byte stream on a valid/ready handshake. Frame layout:
//   SYNC_BYTE, LEN, 4*(LEN+1) data bytes (LSB first), XOR checksum.
//   Each completed word is written to program memory through a one-cycle
//   write port. The CPU is held in reset while a load is in progress and
//   stays held if the checksum fails.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 one-cycle pulse arming a load (IDLE/DONE/ERR only)
//   byte_in, byte_valid   stream data and its valid
//   byte_ready            registered, depends on state only
//   pmem_we_c0            one-cycle write strobe
//   pmem_addr_c0          word-aligned byte address
//   pmem_wdata_c0         write data
//   cpu_hold              CPU reset hold
//   busy, done, error     load status
//   word_count            words written in current or last load (saturating)
//
// state  | meaning
// -------+------------------------------------------------------
// IDLE   | after reset, waiting for start
// SYNC   | discarding bytes until SYNC_BYTE
// LEN    | next byte is the word count minus one
// DATA   | assembling words, writing each on its 4th byte
// CSUM   | next byte is compared against the XOR accumulator
// DONE   | load good, CPU released
// ERR    | checksum failed, CPU still held
module pmem_loader #(
    parameter int         ADDR_W    = 10,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              pmem_we_c0,
    output logic [ADDR_W-1:0] pmem_addr_c0,
    output logic [31:0]       pmem_wdata_c0,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-2:0] word_count
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [ADDR_W-2:0] WC_MAX = {1'b1, {IDX_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state;
    logic [7:0]       len_q;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic [23:0]      lane_buf;
    logic [7:0]       acc;
    logic             accept;

    assign accept = byte_valid & byte_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            len_q         <= 8'd0;
            word_idx      <= '0;
            lane          <= 2'd0;
            lane_buf      <= 24'd0;
            acc           <= 8'd0;
            byte_ready    <= 1'b0;
            pmem_we_c0    <= 1'b0;
            pmem_addr_c0  <= '0;
            pmem_wdata_c0 <= 32'd0;
            cpu_hold      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            word_count    <= '0;
        end else begin
            pmem_we_c0 <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_SYNC;
                        word_count <= '0;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        acc        <= 8'd0;
                        cpu_hold   <= 1'b1;
                        busy       <= 1'b1;
                        byte_ready <= 1'b1;
                    end
                end
                S_SYNC: begin
                    if (accept && byte_in == SYNC_BYTE) begin
                        state <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        len_q    <= byte_in;
                        lane     <= 2'd0;
                        word_idx <= '0;
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        acc  <= acc ^ byte_in;
                        lane <= lane + 2'd1;
                        case (lane)
                            2'd0: lane_buf[7:0]   <= byte_in;
                            2'd1: lane_buf[15:8]  <= byte_in;
                            2'd2: lane_buf[23:16] <= byte_in;
                            default: begin
                                pmem_we_c0    <= 1'b1;
                                pmem_addr_c0  <= {word_idx, 2'b00};
                                pmem_wdata_c0 <= {byte_in, lane_buf};
                                word_idx      <= word_idx + 1'b1;
                                if (word_count != WC_MAX) begin
                                    word_count <= word_count + 1'b1;
                                end
                                // Leaving DATA here keeps word_idx from
                                // ever being used after it wraps.
                                if (word_idx == IDX_W'(len_q)) begin
                                    state <= S_CSUM;
                                end
                            end
                        endcase
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        if (byte_in == acc) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            state    <= S_DONE;
                        end else begin
                            error <= 1'b1;
                            state <= S_ERR;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_loader.sv
// Directed bench for pmem_loader: drives framed byte streams, records every
// write strobe and compares against hand-computed words and status.
module tb_pmem_loader;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        pmem_we_c0;
    logic [9:0]  pmem_addr_c0;
    logic [31:0] pmem_wdata_c0;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  word_count;

    int n_vec;
    int n_err;

    logic [7:0]  frame[$];
    logic [9:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [9:0]  exp_addr[$];
    logic [31:0] exp_data[$];

    pmem_loader #(.ADDR_W(10), .SYNC_BYTE(8'hA5)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .pmem_we_c0    (pmem_we_c0),
        .pmem_addr_c0  (pmem_addr_c0),
        .pmem_wdata_c0 (pmem_wdata_c0),
        .cpu_hold      (cpu_hold),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .word_count    (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pmem_we_c0) begin
            wr_addr.push_back(pmem_addr_c0);
            wr_data.push_back(pmem_wdata_c0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic r;
        bit   ok;
        ok = 1'b0;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        for (int n = 0; n < 20; n++) begin
            r = byte_ready;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        byte_valid = 1'b0;
        if (!ok) chk("byte_accept", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input bit gaps);
        foreach (frame[i]) send_byte(frame[i], gaps ? int'($urandom_range(0, 2)) : 0);
    endtask

    task automatic clear_wr();
        wr_addr.delete();
        wr_data.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic check_writes(input string tag);
        repeat (2) @(negedge clk);
        chk({tag, "_nwr"}, wr_addr.size(), exp_addr.size());
        foreach (exp_addr[i]) begin
            if (i < wr_addr.size()) begin
                chk({tag, "_addr"}, {22'd0, wr_addr[i]}, {22'd0, exp_addr[i]});
                chk({tag, "_data"}, wr_data[i], exp_data[i]);
            end
        end
    endtask

    task automatic load_good_frame();
        frame = '{8'hA5, 8'h01, 8'h13, 8'h01, 8'h00, 8'h00,
                  8'h13, 8'h04, 8'h00, 8'h00, 8'h05};
        exp_addr = '{10'h000, 10'h004};
        exp_data = '{32'h0000_0113, 32'h0000_0413};
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", byte_ready, 1'b0);
        chk("rst_we", pmem_we_c0, 1'b0);
        chk("rst_hold", cpu_hold, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_status", {done, error}, 2'b00);
        chk("rst_addr", pmem_addr_c0, 10'd0);
        chk("rst_wdata", pmem_wdata_c0, 32'd0);
        chk("rst_wc", word_count, 9'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", byte_ready, 1'b0);

        // Good frame, back to back.
        clear_wr();
        load_good_frame();
        pulse_start();
        chk("g_hold", cpu_hold, 1'b1);
        chk("g_ready", byte_ready, 1'b1);
        chk("g_busy", busy, 1'b1);
        send_frame(1'b0);
        chk("g_done", done, 1'b1);
        chk("g_error", error, 1'b0);
        chk("g_hold_rel", cpu_hold, 1'b0);
        chk("g_busy_end", busy, 1'b0);
        chk("g_ready_end", byte_ready, 1'b0);
        chk("g_wc", word_count, 9'd2);
        check_writes("g");

        // Bad checksum.
        clear_wr();
        load_good_frame();
        frame[10] = 8'h06;
        pulse_start();
        chk("b_done_clr", done, 1'b0);
        send_frame(1'b0);
        chk("b_error", error, 1'b1);
        chk("b_done", done, 1'b0);
        chk("b_hold", cpu_hold, 1'b1);
        chk("b_busy", busy, 1'b0);
        chk("b_wc", word_count, 9'd2);
        check_writes("b");
        pulse_start();
        chk("b_err_clr", error, 1'b0);
        chk("b_wc_clr", word_count, 9'd0);

        // Garbage before sync with valid gaps (load already armed).
        clear_wr();
        frame = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h93};
        exp_addr = '{10'h000};
        exp_data = '{32'h0000_0093};
        send_frame(1'b1);
        chk("s_done", done, 1'b1);
        chk("s_error", error, 1'b0);
        chk("s_wc", word_count, 9'd1);
        check_writes("s");

        // Full memory: 256 words of an incrementing byte pattern.
        clear_wr();
        frame = '{8'hA5, 8'hFF};
        for (int i = 0; i < 1024; i++) frame.push_back(8'(i));
        frame.push_back(8'h00);  // XOR of 0..255 taken four times
        for (int k = 0; k < 256; k++) begin
            exp_addr.push_back(10'(4 * k));
            exp_data.push_back({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
        end
        pulse_start();
        send_frame(1'b0);
        chk("f_done", done, 1'b1);
        chk("f_wc", word_count, 9'd256);
        check_writes("f");

        // Reset in the middle of DATA.
        clear_wr();
        pulse_start();
        frame = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_frame(1'b0);
        chk("r_nwr_pre", wr_addr.size(), 1);
        chk("r_busy_pre", busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("r_hold", cpu_hold, 1'b0);
        chk("r_ready", byte_ready, 1'b0);
        chk("r_busy", busy, 1'b0);
        chk("r_we", pmem_we_c0, 1'b0);
        chk("r_addr", pmem_addr_c0, 10'd0);
        chk("r_wdata", pmem_wdata_c0, 32'd0);
        chk("r_wc", word_count, 9'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("r_nwr", wr_addr.size(), 1);
        if (wr_addr.size() > 0) chk("r_wdata0", wr_data[0], 32'h4433_2211);
        clear_wr();
        load_good_frame();
        pulse_start();
        send_frame(1'b0);
        chk("r2_done", done, 1'b1);
        chk("r2_wc", word_count, 9'd2);
        check_writes("r2");

        // start pulsed during DATA is ignored.
        clear_wr();
        load_good_frame();
        pulse_start();
        for (int i = 0; i < 11; i++) begin
            if (i == 4 || i == 8) start = 1'b1;
            send_byte(frame[i], 0);
            if (i == 8) chk("x_wc_mid", word_count, 9'd1);
        end
        chk("x_done", done, 1'b1);
        chk("x_error", error, 1'b0);
        chk("x_wc", word_count, 9'd2);
        check_writes("x");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
